blink_rate_ctrl: RTL
====================

Name: blink_rate_ctrl

Overview:
- Mode controller that sequences the LED blink divider from one push button.
- Debounces a raw button and steps through blink modes: OFF, SLOW, FAST, BURST.
- Runs one shared half-period divider at the rate of the current mode.
- Sits between the board button/slide switch and the status LED. Replaces fixed SW-selected rates with a sequenced mode set.

Parameters:
- CLK_HZ, 50_000_000: input clock frequency in Hz. Must be a multiple of 16.
- DEB_CYC, 1_000_000: consecutive stable cycles required to accept a button level (20 ms at 50 MHz). Must be ≥ 2.
- BURST_CNT, 5: full blinks (on+off) emitted in BURST before auto-return. Range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset. 0 clears all state immediately.
- btn  input  1  raw asynchronous push button, active-high, bouncy.
- SW  input  1  run enable. 1 = divider runs, 0 = divider paused.
- led  output  1  blink output.
- mode  output  2  current mode: 00 OFF, 01 SLOW, 10 FAST, 11 BURST.
- tick  output  1  one-cycle pulse on every led toggle.

Behaviour:
- Reset (reset=0, async): led=0, tick=0, mode=00, divider count=0, burst count=0, sync FFs=0, debounced level=0, filter count=0.
- Sync: btn passes through 2 FFs. No logic on the raw input.
- Debounce filter:
  - While the synced value differs from the debounced level, the filter count increments. When they are equal, the count clears.
  - When the count reaches DEB_CYC-1 and the values still differ, the debounced level takes the synced value and the count clears.
  - A glitch shorter than DEB_CYC cycles is rejected.
- btn_evt: registered one-cycle pulse on a 0→1 debounced transition. Release generates no event.
- Latency: mode updates on clock edge DEB_CYC+3, counted from the first edge that samples btn=1.
- Mode FSM on btn_evt: OFF→SLOW→FAST→BURST→OFF.
- Half periods (H):
  - SLOW: CLK_HZ/2 (1 Hz blink).
  - FAST: CLK_HZ/4 (2 Hz).
  - BURST: CLK_HZ/16 (8 Hz).
- Divider:
  - Counter width is clog2(CLK_HZ/2). It counts 0..H-1.
  - At H-1 the counter wraps to 0, led toggles and tick=1 for that same cycle.
- OFF mode: led=0, tick=0, counter held at 0.
- Mode change: on the btn_evt edge, counter←0, led←0 and burst count←0. The new rate starts cleanly, so the first toggle comes H cycles later.
- Burst count: increments on each led 1→0 toggle in BURST. When it reaches BURST_CNT, on that same edge: mode←SLOW, counter←0, led←0, burst count←0, and tick=1 for that toggle.
- Simultaneous btn_evt and burst completion: btn_evt wins and mode goes to OFF.
- SW=0:
  - Counter, led and burst count hold. tick=0.
  - btn_evt still changes mode and still clears counter and led.
  - When SW returns to 1, counting resumes from the held value.
- reset asserted mid-operation (mid-burst or mid-debounce): immediate return to the reset state. No pending events survive.

Optional Feature:
- Macro BURST_LOOP_EN.
- When defined: BURST never auto-returns. The burst count wraps to 0 after BURST_CNT blinks, and led/divider continue without clearing. Only btn_evt leaves BURST.
- When undefined: auto-return to SLOW after BURST_CNT blinks, as specified above.

Test Plan (CLK_HZ=64, DEB_CYC=4, BURST_CNT=3; H = SLOW 32, FAST 16, BURST 4):
- Reset: hold reset=0 with btn=1 and SW=1 → led=0, mode=00, tick=0. Release, hold btn=1 → mode=01 exactly 7 edges after the first sampling edge.
- Bounce: pulse btn 1 for 3 cycles, 0 for 2, repeat 5 times → mode stays 00. Then hold 1 for 10 cycles → mode=01.
- SLOW rate: mode=01, SW=1 → tick every 32 cycles and led period 64 cycles. Set SW=0 for 50 cycles → led frozen and no tick. Resume → next toggle after the remaining count.
- Sequence: press 3 times from OFF → mode 01, 10, 11 in turn. In FAST, tick every 16 cycles. Press again → mode=00, led=0.
- Burst: enter BURST → 6 toggles at 4-cycle spacing, then mode=01 on the 6th toggle edge with led=0. With BURST_LOOP_EN, still mode=11 after 100 cycles.
- Collision: time btn_evt onto the burst-completion edge → mode=00, not 01. Assert reset mid-burst → all outputs 0 asynchronously.

Source files
------------

// File: rtl/blink_rate_ctrl_if.sv
// rtl/blink_rate_ctrl_if.sv - button/switch inputs and LED status outputs of the blink controller
interface blink_rate_ctrl_if;
    logic       btn;
    logic       SW;
    logic       led;
    logic [1:0] mode;
    logic       tick;

    // Board side: drives the raw button and the run switch, observes the LED status
    modport master (
        output btn,
        output SW,
        input  led,
        input  mode,
        input  tick
    );

    // Controller side
    modport slave (
        input  btn,
        input  SW,
        output led,
        output mode,
        output tick
    );
endinterface

// File: rtl/blink_rate_ctrl.sv
// rtl/blink_rate_ctrl.sv - debounced push-button mode sequencer driving a shared LED blink divider (option: BURST_LOOP_EN)
module blink_rate_ctrl #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int DEB_CYC   = 1_000_000,
    parameter int BURST_CNT = 5
) (
    input  logic               clk,
    input  logic               reset,
    blink_rate_ctrl_if.slave   bus
);

    localparam int DW = $clog2(DEB_CYC);
    localparam int CW = $clog2(CLK_HZ / 2);

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYC - 1);
    localparam logic [CW-1:0] LAST_SLOW  = CW'(CLK_HZ / 2 - 1);
    localparam logic [CW-1:0] LAST_FAST  = CW'(CLK_HZ / 4 - 1);
    localparam logic [CW-1:0] LAST_BURST = CW'(CLK_HZ / 16 - 1);
    localparam logic [3:0]    BURST_LAST = 4'(BURST_CNT - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_SLOW  = 2'b01,
        MODE_FAST  = 2'b10,
        MODE_BURST = 2'b11
    } mode_e;

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_d;
    logic [DW-1:0] deb_cnt_q;
    logic [DW-1:0] deb_cnt_d;
    logic          btn_evt_q;
    logic          btn_evt_d;

    mode_e         mode_q;
    mode_e         mode_next;
    logic [CW-1:0] div_q;
    logic [CW-1:0] half_last;
    logic          led_q;
    logic          tick_q;
    logic [3:0]    burst_q;

    // Two-flop synchronizer on the raw button; nothing else touches the raw input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.btn;
            sync2_q <= sync1_q;
        end
    end

    // Filter next state: a level is accepted only after DEB_CYC consecutive differing samples
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        btn_evt_d = 1'b0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d     = sync2_q;
                btn_evt_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Debounced level, filter count and the press event pulse (release makes no event)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
            btn_evt_q <= 1'b0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            btn_evt_q <= btn_evt_d;
        end
    end

    // Mode rotation and the terminal count of the half-period divider for the current mode
    always_comb begin
        mode_next = MODE_OFF;
        half_last = LAST_SLOW;
        case (mode_q)
            MODE_OFF:   mode_next = MODE_SLOW;
            MODE_SLOW:  mode_next = MODE_FAST;
            MODE_FAST:  mode_next = MODE_BURST;
            MODE_BURST: mode_next = MODE_OFF;
            default:    mode_next = MODE_OFF;
        endcase
        case (mode_q)
            MODE_FAST:  half_last = LAST_FAST;
            MODE_BURST: half_last = LAST_BURST;
            default:    half_last = LAST_SLOW;
        endcase
    end

    // Mode FSM with divider, LED, tick and burst counting; a press outranks burst completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q  <= MODE_OFF;
            div_q   <= '0;
            led_q   <= 1'b0;
            tick_q  <= 1'b0;
            burst_q <= '0;
        end else begin
            tick_q <= 1'b0;
            if (btn_evt_q) begin
                // New rate starts cleanly from a dark LED
                mode_q  <= mode_next;
                div_q   <= '0;
                led_q   <= 1'b0;
                burst_q <= '0;
            end else if (mode_q == MODE_OFF) begin
                div_q   <= '0;
                led_q   <= 1'b0;
                burst_q <= '0;
            end else if (bus.SW) begin
                if (div_q == half_last) begin
                    div_q  <= '0;
                    led_q  <= ~led_q;
                    tick_q <= 1'b1;
                    // A full blink ends on the 1->0 toggle
                    if (mode_q == MODE_BURST && led_q) begin
                        if (burst_q == BURST_LAST) begin
`ifdef BURST_LOOP_EN
                            burst_q <= '0;
`else
                            mode_q  <= MODE_SLOW;
                            burst_q <= '0;
`endif
                        end else begin
                            burst_q <= burst_q + 1'b1;
                        end
                    end
                end else begin
                    div_q <= div_q + 1'b1;
                end
            end
        end
    end

    assign bus.led  = led_q;
    assign bus.mode = mode_q;
    assign bus.tick = tick_q;

endmodule
